// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: bundles pipeline-side requests (master) and scheduler outputs (slave)
interface pipeline_ctrl_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      if_stall_request;
  logic                      id_stall_request;
  logic                      ex_stall_request;
  logic                      mem_stall_request;
  logic                      id_reg_read_en_1;
  logic                      id_reg_read_en_2;
  logic [REG_ADDR_WIDTH-1:0] id_reg_addr_1;
  logic [REG_ADDR_WIDTH-1:0] id_reg_addr_2;
  logic                      ex_mem_read_flag;
  logic [REG_ADDR_WIDTH-1:0] ex_reg_write_addr;
  logic                      exc_request;
  logic [ADDR_WIDTH-1:0]     exc_target;
  logic                      stat_clear;
  logic                      load_related_1;
  logic                      load_related_2;
  logic [5:0]                stall;
  logic                      flush;
  logic [ADDR_WIDTH-1:0]     flush_pc_addr;
  logic [31:0]               stall_cycles;
  logic                      stall_timeout;
  modport master (
    output if_stall_request, id_stall_request, ex_stall_request, mem_stall_request,
           id_reg_read_en_1, id_reg_read_en_2, id_reg_addr_1, id_reg_addr_2,
           ex_mem_read_flag, ex_reg_write_addr, exc_request, exc_target, stat_clear,
    input  load_related_1, load_related_2, stall, flush, flush_pc_addr,
           stall_cycles, stall_timeout
  );
  modport slave (
    input  if_stall_request, id_stall_request, ex_stall_request, mem_stall_request,
           id_reg_read_en_1, id_reg_read_en_2, id_reg_addr_1, id_reg_addr_2,
           ex_mem_read_flag, ex_reg_write_addr, exc_request, exc_target, stat_clear,
    output load_related_1, load_related_2, stall, flush, flush_pc_addr,
           stall_cycles, stall_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: load-use detection, stall merge, exception flush sequencing, stall stats and watchdog
module pipeline_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int STALL_LIMIT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);
  localparam int WDW = $clog2(STALL_LIMIT + 1);
  typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;
  state_t                r_state, w_next;
  logic [5:0]            w_merge, w_stall;
  logic                  w_exc, w_any;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [31:0]           r_cycles;
  logic [WDW-1:0]        r_wd;
  logic                  r_timeout;
  assign bus.load_related_1 = bus.ex_mem_read_flag & bus.id_reg_read_en_1 &
                              (bus.id_reg_addr_1 == bus.ex_reg_write_addr) & (|bus.ex_reg_write_addr);
  assign bus.load_related_2 = bus.ex_mem_read_flag & bus.id_reg_read_en_2 &
                              (bus.id_reg_addr_2 == bus.ex_reg_write_addr) & (|bus.ex_reg_write_addr);
  // the furthest-down requester freezes itself and everything upstream
  assign w_merge = bus.mem_stall_request ? 6'b011111 :
                   bus.ex_stall_request  ? 6'b001111 :
                   bus.id_stall_request  ? 6'b000111 :
                   bus.if_stall_request  ? 6'b000011 : 6'b000000;
  assign w_exc = (r_state == RUN) & bus.exc_request;
  always_comb begin
    w_next  = RUN;
    w_stall = w_merge;
    case (r_state)
      RUN:     begin
        w_next  = w_exc ? FLUSH : RUN;
        w_stall = w_exc ? 6'b111111 : w_merge;
      end
      FLUSH:   begin
        w_next  = RECOVER;
        w_stall = 6'b000000;
      end
      default: w_next = RUN;
    endcase
  end
  assign w_any = |w_stall;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RUN;
      r_pc      <= '0;
      r_cycles  <= '0;
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pc      <= w_exc ? bus.exc_target : r_pc;
      r_cycles  <= bus.stat_clear ? 32'd0 : (w_any && !(&r_cycles)) ? r_cycles + 32'd1 : r_cycles;
      r_wd      <= !w_any ? '0 : (r_wd == WDW'(STALL_LIMIT)) ? r_wd : r_wd + 1'b1;
      r_timeout <= r_timeout | (w_any && r_wd == WDW'(STALL_LIMIT - 1));
    end
  end
  assign bus.stall         = w_stall;
  assign bus.flush         = (r_state == FLUSH);
  assign bus.flush_pc_addr = r_pc;
  assign bus.stall_cycles  = r_cycles;
  assign bus.stall_timeout = r_timeout;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl with STALL_LIMIT=8
module tb_pipeline_ctrl;
  typedef struct {logic [5:0] s; logic f;} exp_t;
  logic        clk, rst, en;
  int          n_err, n_chk;
  exp_t        sb[$];
  logic [31:0] pc_q[$];
  logic [5:0]  exp_cur;
  logic [31:0] m_sc;
  int          m_wd;
  logic        m_to;
  exp_t        e;
  pipeline_ctrl_if #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) bus();
  pipeline_ctrl #(.ADDR_WIDTH(32), .STALL_LIMIT(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // reference model of statistics, driven by the expected stall vector
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_sc <= 0;
      m_wd <= 0;
      m_to <= 0;
    end else begin
      m_sc <= bus.stat_clear ? 32'd0 : (exp_cur != 0 && m_sc != 32'hFFFFFFFF) ? m_sc + 1 : m_sc;
      m_wd <= (exp_cur != 0) ? m_wd + 1 : 0;
      m_to <= m_to | (exp_cur != 0 && m_wd == 7);
    end
  end
  always @(negedge clk) begin
    if (en) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall", 32'(bus.stall), 32'(e.s));
        chk("flush", 32'(bus.flush), 32'(e.f));
      end
      if (bus.flush) begin
        if (pc_q.size() > 0) chk("flush_pc", bus.flush_pc_addr, pc_q.pop_front());
        else chk("spurious_flush", 32'(bus.flush), 32'd0);
      end
      chk("stall_cycles", bus.stall_cycles, m_sc);
      chk("timeout", 32'(bus.stall_timeout), 32'(m_to));
    end
  end
  task automatic step(input logic [3:0] req, input logic exc, input logic [31:0] tgt,
                      input logic clr, input logic [5:0] es, input logic ef);
    @(posedge clk); #1;
    {bus.mem_stall_request, bus.ex_stall_request, bus.id_stall_request, bus.if_stall_request} = req;
    bus.exc_request = exc;
    bus.exc_target  = tgt;
    bus.stat_clear  = clr;
    exp_cur = es;
    sb.push_back('{es, ef});
    if (exc && es == 6'h3f) pc_q.push_back(tgt);
  endtask
  initial begin
    n_err = 0; n_chk = 0; en = 0; exp_cur = 0;
    {bus.mem_stall_request, bus.ex_stall_request, bus.id_stall_request, bus.if_stall_request} = 4'b0;
    bus.id_reg_read_en_1 = 0; bus.id_reg_read_en_2 = 0;
    bus.id_reg_addr_1 = 0; bus.id_reg_addr_2 = 0;
    bus.ex_mem_read_flag = 0; bus.ex_reg_write_addr = 0;
    bus.exc_request = 0; bus.exc_target = 0; bus.stat_clear = 0;
    rst = 1; #1 rst = 0; #2;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_pc", bus.flush_pc_addr, 32'd0);
    chk("rst_cycles", bus.stall_cycles, 32'd0);
    chk("rst_timeout", 32'(bus.stall_timeout), 32'd0);
    chk("rst_lr", 32'({bus.load_related_1, bus.load_related_2}), 32'd0);
    #19 rst = 1; en = 1;
    step(4'b0000, 0, 0, 0, 6'h00, 0);
    bus.ex_mem_read_flag = 1; bus.ex_reg_write_addr = 5;
    bus.id_reg_read_en_2 = 1; bus.id_reg_addr_2 = 5;
    bus.id_reg_read_en_1 = 1; bus.id_reg_addr_1 = 3;
    #1 chk("lu_port2", 32'(bus.load_related_2), 32'd1);
    chk("lu_port1", 32'(bus.load_related_1), 32'd0);
    bus.ex_reg_write_addr = 0; bus.id_reg_addr_2 = 0; bus.id_reg_addr_1 = 0;
    #1 chk("lu_zero", 32'({bus.load_related_1, bus.load_related_2}), 32'd0);
    bus.ex_reg_write_addr = 7; bus.id_reg_addr_1 = 7; bus.id_reg_read_en_1 = 0;
    #1 chk("lu_en_off", 32'(bus.load_related_1), 32'd0);
    bus.id_reg_read_en_1 = 1;
    #1 chk("lu_port1_hit", 32'(bus.load_related_1), 32'd1);
    bus.ex_mem_read_flag = 0;
    #1 chk("lu_no_load", 32'(bus.load_related_1), 32'd0);
    step(4'b0101, 0, 0, 0, 6'b001111, 0);
    step(4'b1101, 0, 0, 0, 6'b011111, 0);
    step(4'b0010, 0, 0, 0, 6'b000111, 0);
    step(4'b0001, 0, 0, 0, 6'b000011, 0);
    step(4'b0000, 0, 0, 0, 6'b000000, 0);
    step(4'b1000, 1, 32'hBFC00380, 0, 6'b111111, 0);
    step(4'b1000, 1, 32'h12345678, 0, 6'b000000, 1);
    step(4'b0001, 1, 32'h0BAD0BAD, 0, 6'b000011, 0);
    step(4'b0000, 0, 0, 0, 6'b000000, 0);
    step(4'b0000, 1, 32'h80000180, 0, 6'b111111, 0);
    step(4'b0000, 0, 0, 0, 6'b000000, 1);
    step(4'b0000, 0, 0, 0, 6'b000000, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 7; i++) step(4'b1000, 0, 0, 0, 6'b011111, 0);
      step(4'b0000, 0, 0, 0, 6'b000000, 0);
    end
    chk("wd_short", 32'(bus.stall_timeout), 32'd0);
    for (int i = 0; i < 8; i++) step(4'b1000, 0, 0, 0, 6'b011111, 0);
    step(4'b0000, 0, 0, 0, 6'b000000, 0);
    step(4'b0000, 0, 0, 0, 6'b000000, 0);
    chk("wd_trip", 32'(bus.stall_timeout), 32'd1);
    for (int i = 0; i < 10; i++) step(4'b0100, 0, 0, 0, 6'b001111, 0);
    step(4'b0100, 0, 0, 1, 6'b001111, 0);
    for (int i = 0; i < 3; i++) step(4'b0100, 0, 0, 0, 6'b001111, 0);
    step(4'b0000, 0, 0, 0, 6'b000000, 0);
    step(4'b0000, 1, 32'hDEAD0040, 0, 6'b111111, 0);
    @(posedge clk); #1;
    bus.exc_request = 0; exp_cur = 0;
    chk("pre_rst_flush", 32'(bus.flush), 32'd1);
    chk("pre_rst_pc", bus.flush_pc_addr, pc_q.pop_front());
    #1 rst = 0;
    #1 chk("async_flush", 32'(bus.flush), 32'd0);
    chk("async_cycles", bus.stall_cycles, 32'd0);
    chk("async_timeout", 32'(bus.stall_timeout), 32'd0);
    #4 rst = 1;
    step(4'b0000, 0, 0, 0, 6'b000000, 0);
    step(4'b1000, 1, 32'h00400000, 0, 6'b111111, 0);
    step(4'b0000, 0, 0, 0, 6'b000000, 1);
    step(4'b0000, 0, 0, 0, 6'b000000, 0);
    step(4'b0000, 0, 0, 0, 6'b000000, 0);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline scheduler for the five-stage MIPS32 core. It detects load-use hazards for the decode stage and merges per-stage stall requests into a per-stage stall vector. It sequences exception flushes through a small state machine and keeps stall statistics plus a stall watchdog. It sits beside the IF/ID/EX/MEM/WB pipeline registers and drives their stall and flush inputs; its `load_related_1/2` outputs feed the decode stage.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of PC and flush target addresses
- `REG_ADDR_WIDTH`, 5, register index width
- `STALL_LIMIT`, 1024, consecutive stalled cycles that trip the watchdog (≥2)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_stall_request`  in  1  fetch not ready
- `id_stall_request`  in  1  decode stall (includes load-use)
- `ex_stall_request`  in  1  multi-cycle EX op busy
- `mem_stall_request`  in  1  data memory not ready
- `id_reg_read_en_1`, `id_reg_read_en_2`  in  1  decode read-port enables
- `id_reg_addr_1`, `id_reg_addr_2`  in  REG_ADDR_WIDTH  decode read-port indices
- `ex_mem_read_flag`  in  1  instruction now in EX is a load
- `ex_reg_write_addr`  in  REG_ADDR_WIDTH  destination of instruction in EX
- `exc_request`  in  1  exception raised in MEM
- `exc_target`  in  ADDR_WIDTH  handler address
- `stat_clear`  in  1  synchronous clear of `stall_cycles`
- `load_related_1`, `load_related_2`  out  1  load-use hazard on read port 1/2
- `stall`  out  6  bit0 PC, bit1 IF/ID reg, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
- `flush`  out  1  clear all pipeline registers
- `flush_pc_addr`  out  ADDR_WIDTH  PC redirect target, valid while `flush`=1
- `stall_cycles`  out  32  saturating count of cycles with `stall`≠0
- `stall_timeout`  out  1  sticky watchdog flag

## Operation
- Load-use, combinational: `load_related_k` = `ex_mem_read_flag` & `id_reg_read_en_k` & (`id_reg_addr_k` == `ex_reg_write_addr`) & (`ex_reg_write_addr` ≠ 0).
- Stall merge, combinational. The highest-numbered requester wins. It freezes its own stage and all earlier stages. Later stages advance, which inserts a bubble.
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 0
- FSM states: RUN, FLUSH, RECOVER.
  - RUN: if `exc_request`=1, `stall`=6'b111111 this cycle and go to FLUSH. `exc_target` is latched into `flush_pc_addr`. The exception overrides all stall requests.
  - FLUSH: `flush`=1, `stall`=0, requests ignored; go to RECOVER.
  - RECOVER: `flush`=0, normal stall merge; `exc_request` ignored; go to RUN.
- `flush` is a registered output: high exactly one cycle, the cycle after `exc_request` is sampled in RUN.
- `stall_cycles`:
  - Increments each cycle the final `stall`≠0, including the exception freeze cycle.
  - Saturates at 32'hFFFFFFFF.
  - `stat_clear` takes priority over the increment and loads 0.
- Watchdog:
  - An internal counter increments each cycle `stall`≠0 and resets to 0 on any cycle with `stall`=0.
  - `stall_timeout` is set on the cycle the counter reaches `STALL_LIMIT`. It stays set until reset; `stat_clear` does not clear it.

## Timing
- Reset (async assert, sync-safe deassert):
  - state = RUN
  - `flush` = 0, `flush_pc_addr` = 0
  - `stall_cycles` = 0, watchdog counter = 0, `stall_timeout` = 0
  - combinational outputs follow inputs; with idle inputs `stall` = 0 and `load_related_*` = 0
- Reset asserted during FLUSH or RECOVER returns to RUN immediately and drops `flush`.
- `load_related_*` and `stall` have zero latency in RUN and RECOVER.
- Exception sequence:
  - Cycle N: `exc_request`, `stall`=111111.
  - Cycle N+1: `flush`=1, `flush_pc_addr`=`exc_target`@N.
  - Cycle N+2: RECOVER.
  - Earliest next accepted exception: cycle N+3.
- Simultaneous `exc_request` and `mem_stall_request` in RUN: the exception wins.
- A counter increment and the watchdog trip in the same cycle are both visible on the next edge.

## Test plan
- Load in EX writing $5, ID reads $5 on port 2 with enable → `load_related_2`=1, `load_related_1`=0. Same case with destination $0 → both 0.
- `ex_stall_request` and `if_stall_request` together → `stall`=6'b001111. Add `mem_stall_request` → 6'b011111. Release all → 0.
- `exc_request`=1 with `exc_target`=32'hBFC00380 in RUN → `stall`=111111 at N. At N+1, `flush`=1 and `flush_pc_addr`=32'hBFC00380. At N+2, `flush`=0. A second `exc_request` at N+1 or N+2 is ignored.
- 10 stalled cycles, then `stat_clear` for one cycle while stalled → `stall_cycles` reaches 10, then reads 0, then resumes counting from 1.
- `STALL_LIMIT`=8, hold `mem_stall_request` for 8 cycles → `stall_timeout` rises after the 8th cycle and stays 1 after the request drops. With 7 stalled cycles, 1 free, 7 stalled → stays 0.
- Assert `rst` low during FLUSH → `flush`=0 immediately. After release, state is RUN and `stall_cycles`=0.
